// File: rtl/xbar_rtn_rob.sv
// Per-channel reorder buffer behind the SRAM controller xbar return port.
// Hands out rob numbers, captures tagged out-of-order returns and retires them in order.
module xbar_rtn_rob (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         alloc_valid_i,
    output logic         alloc_ready_o,
    input  logic [1:0]   alloc_channel_id_i,
    output logic [2:0]   alloc_rob_num_o,
    input  logic         sc_xbar_valid_i,
    output logic         sc_xbar_ready_o,
    input  logic [1:0]   sc_xbar_channel_id_i,
    input  logic [2:0]   sc_xbar_rob_num_i,
    input  logic [127:0] sc_xbar_data_i,
    output logic         rob_rsp_valid_o,
    input  logic         rob_rsp_ready_i,
    output logic [1:0]   rob_rsp_channel_id_o,
    output logic [127:0] rob_rsp_data_o,
    output logic [3:0]   rob_ch_empty_o,
    output logic         rob_err_o
);
    localparam int unsigned CH_NUM    = 4;
    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned DW        = 128;
    localparam int unsigned CW        = 2;
    localparam int unsigned RW        = 3;
    localparam int unsigned PW        = RW + 1;

    logic [CH_NUM-1:0][PW-1:0]        alloc_ptr_q, alloc_ptr_d;
    logic [CH_NUM-1:0][PW-1:0]        retire_ptr_q, retire_ptr_d;
    logic [CH_NUM-1:0][ROB_DEPTH-1:0] alloc_v_q, alloc_v_d;
    logic [CH_NUM-1:0][ROB_DEPTH-1:0] fill_v_q, fill_v_d;
    logic [CW-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]                    lock_ch_q, lock_ch_d;
    logic                             lock_q, lock_d;
    logic                             err_q, err_d;
    logic [DW-1:0]                    data_q [CH_NUM][ROB_DEPTH];

    logic [CH_NUM-1:0] full;
    logic [CH_NUM-1:0] empty;
    logic [CH_NUM-1:0] cand;
    logic              alloc_hs;
    logic              fill_hs;
    logic              fill_ok;
    logic              rsp_hs;
    logic [CW-1:0]     pick_ch;
    logic [CW-1:0]     scan_ch;
    logic [CW-1:0]     grant_ch;
    logic [RW-1:0]     head_rob;

    // Occupancy and head-ready flags, all from registered pointers.
    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        assign full[c]  = (alloc_ptr_q[c][RW-1:0] == retire_ptr_q[c][RW-1:0]) &&
                          (alloc_ptr_q[c][RW] != retire_ptr_q[c][RW]);
        assign empty[c] = (alloc_ptr_q[c] == retire_ptr_q[c]);
        assign cand[c]  = fill_v_q[c][retire_ptr_q[c][RW-1:0]];
    end

    // Round-robin scan from rr_ptr; highest offset first so the nearest candidate wins.
    always_comb begin
        pick_ch = rr_ptr_q;
        scan_ch = '0;
        for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            scan_ch = rr_ptr_q + CW'(i);
            if (cand[scan_ch]) begin
                pick_ch = scan_ch;
            end
        end
    end

    assign grant_ch = lock_q ? lock_ch_q : pick_ch;
    assign head_rob = retire_ptr_q[grant_ch][RW-1:0];

    assign alloc_ready_o        = !rst_i && !full[alloc_channel_id_i];
    assign alloc_rob_num_o      = alloc_ptr_q[alloc_channel_id_i][RW-1:0];
    assign sc_xbar_ready_o      = !rst_i;
    assign rob_rsp_valid_o      = |cand;
    assign rob_rsp_channel_id_o = grant_ch;
    assign rob_rsp_data_o       = data_q[grant_ch][head_rob];
    assign rob_ch_empty_o       = empty;
    assign rob_err_o            = err_q;

    assign alloc_hs = alloc_valid_i && alloc_ready_o;
    assign fill_hs  = sc_xbar_valid_i && sc_xbar_ready_o;
    assign rsp_hs   = rob_rsp_valid_o && rob_rsp_ready_i;
    // Entries allocated this very cycle are not yet visible here, so such fills error out.
    assign fill_ok  = alloc_v_q[sc_xbar_channel_id_i][sc_xbar_rob_num_i] &&
                      !fill_v_q[sc_xbar_channel_id_i][sc_xbar_rob_num_i];

    always_comb begin
        alloc_ptr_d  = alloc_ptr_q;
        retire_ptr_d = retire_ptr_q;
        alloc_v_d    = alloc_v_q;
        fill_v_d     = fill_v_q;
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        lock_ch_d    = lock_ch_q;
        err_d        = err_q;

        if (alloc_hs) begin
            alloc_v_d[alloc_channel_id_i][alloc_rob_num_o] = 1'b1;
            alloc_ptr_d[alloc_channel_id_i] = alloc_ptr_q[alloc_channel_id_i] + PW'(1);
        end

        if (fill_hs) begin
            if (fill_ok) begin
                fill_v_d[sc_xbar_channel_id_i][sc_xbar_rob_num_i] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // Retire the granted head, or pin the grant while the consumer stalls.
        if (rsp_hs) begin
            alloc_v_d[grant_ch][head_rob] = 1'b0;
            fill_v_d[grant_ch][head_rob]  = 1'b0;
            retire_ptr_d[grant_ch] = retire_ptr_q[grant_ch] + PW'(1);
            rr_ptr_d = grant_ch + CW'(1);
            lock_d   = 1'b0;
        end else if (rob_rsp_valid_o) begin
            lock_d    = 1'b1;
            lock_ch_d = grant_ch;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_ptr_q  <= '0;
            retire_ptr_q <= '0;
            alloc_v_q    <= '0;
            fill_v_q     <= '0;
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_ch_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            alloc_ptr_q  <= alloc_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            alloc_v_q    <= alloc_v_d;
            fill_v_q     <= fill_v_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_ch_q    <= lock_ch_d;
            err_q        <= err_d;
        end
    end

    // Return data storage; not reset.
    always_ff @(posedge clk_i) begin
        if (fill_hs && fill_ok) begin
            data_q[sc_xbar_channel_id_i][sc_xbar_rob_num_i] <= sc_xbar_data_i;
        end
    end

endmodule

// File: tb/tb_xbar_rtn_rob.sv
// Directed bench for xbar_rtn_rob: per-cycle vector tables plus hand sequences
// for wrap-around and mid-operation reset.
module tb_xbar_rtn_rob;
    logic         clk_i;
    logic         rst_i;
    logic         alloc_valid_i;
    logic         alloc_ready_o;
    logic [1:0]   alloc_channel_id_i;
    logic [2:0]   alloc_rob_num_o;
    logic         sc_xbar_valid_i;
    logic         sc_xbar_ready_o;
    logic [1:0]   sc_xbar_channel_id_i;
    logic [2:0]   sc_xbar_rob_num_i;
    logic [127:0] sc_xbar_data_i;
    logic         rob_rsp_valid_o;
    logic         rob_rsp_ready_i;
    logic [1:0]   rob_rsp_channel_id_o;
    logic [127:0] rob_rsp_data_o;
    logic [3:0]   rob_ch_empty_o;
    logic         rob_err_o;

    xbar_rtn_rob dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .alloc_valid_i        (alloc_valid_i),
        .alloc_ready_o        (alloc_ready_o),
        .alloc_channel_id_i   (alloc_channel_id_i),
        .alloc_rob_num_o      (alloc_rob_num_o),
        .sc_xbar_valid_i      (sc_xbar_valid_i),
        .sc_xbar_ready_o      (sc_xbar_ready_o),
        .sc_xbar_channel_id_i (sc_xbar_channel_id_i),
        .sc_xbar_rob_num_i    (sc_xbar_rob_num_i),
        .sc_xbar_data_i       (sc_xbar_data_i),
        .rob_rsp_valid_o      (rob_rsp_valid_o),
        .rob_rsp_ready_i      (rob_rsp_ready_i),
        .rob_rsp_channel_id_o (rob_rsp_channel_id_o),
        .rob_rsp_data_o       (rob_rsp_data_o),
        .rob_ch_empty_o       (rob_ch_empty_o),
        .rob_err_o            (rob_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    localparam int CA = 1;   // alloc_ready
    localparam int CR = 2;   // alloc_rob_num
    localparam int CV = 4;   // rsp_valid
    localparam int CC = 8;   // rsp channel
    localparam int CD = 16;  // rsp data
    localparam int CE = 32;  // ch_empty
    localparam int CX = 64;  // err

    typedef struct {
        string        nm;
        logic         av;
        logic [1:0]   ach;
        logic         fv;
        logic [1:0]   fch;
        logic [2:0]   frob;
        logic [127:0] fdat;
        logic         rdy;
        int           ck;
        logic         e_ardy;
        logic [2:0]   e_rob;
        logic         e_vld;
        logic [1:0]   e_rch;
        logic [127:0] e_dat;
        logic [3:0]   e_emp;
        logic         e_err;
    } vec_t;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    function automatic logic [127:0] dat(input int tag);
        return {32'hC0DE_0000 + 32'(tag), 32'(tag) * 32'd3, 32'hFEED_0000 | 32'(tag), ~32'(tag)};
    endfunction

    function automatic vec_t vv(input string nm, input int av, input int ach,
                                input int fv, input int fch, input int frob, input int ftag,
                                input int rdy, input int ck, input int ardy, input int rob,
                                input int vld, input int rch, input int etag,
                                input int emp, input int err);
        vec_t t;
        t.nm = nm;       t.av = 1'(av);     t.ach = 2'(ach);
        t.fv = 1'(fv);   t.fch = 2'(fch);   t.frob = 3'(frob);
        t.fdat = dat(ftag);                 t.rdy = 1'(rdy);
        t.ck = ck;       t.e_ardy = 1'(ardy); t.e_rob = 3'(rob);
        t.e_vld = 1'(vld); t.e_rch = 2'(rch); t.e_dat = dat(etag);
        t.e_emp = 4'(emp); t.e_err = 1'(err);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Drive one cycle of inputs at the falling edge, check outputs before the rising edge.
    task automatic apply(input vec_t t);
        @(negedge clk_i);
        rst_i                = 1'b0;
        alloc_valid_i        = t.av;
        alloc_channel_id_i   = t.ach;
        sc_xbar_valid_i      = t.fv;
        sc_xbar_channel_id_i = t.fch;
        sc_xbar_rob_num_i    = t.frob;
        sc_xbar_data_i       = t.fdat;
        rob_rsp_ready_i      = t.rdy;
        #1;
        if ((t.ck & CA) != 0) chk({t.nm, ".ardy"}, 128'(alloc_ready_o), 128'(t.e_ardy));
        if ((t.ck & CR) != 0) chk({t.nm, ".rob"}, 128'(alloc_rob_num_o), 128'(t.e_rob));
        if ((t.ck & CV) != 0) chk({t.nm, ".vld"}, 128'(rob_rsp_valid_o), 128'(t.e_vld));
        if ((t.ck & CC) != 0) chk({t.nm, ".rch"}, 128'(rob_rsp_channel_id_o), 128'(t.e_rch));
        if ((t.ck & CD) != 0) chk({t.nm, ".dat"}, rob_rsp_data_o, t.e_dat);
        if ((t.ck & CE) != 0) chk({t.nm, ".empty"}, 128'(rob_ch_empty_o), 128'(t.e_emp));
        if ((t.ck & CX) != 0) chk({t.nm, ".err"}, 128'(rob_err_o), 128'(t.e_err));
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    initial begin
        // name, av,ach, fv,fch,frob,ftag, rdy, ck, ardy,rob, vld,rch,etag, emp,err
        // ch0 in-order fill
        tbl_a.push_back(vv("t1_a0", 1,0, 0,0,0,0,  1, CA|CR|CV|CE|CX, 1,0, 0,0,0, 15,0));
        tbl_a.push_back(vv("t1_a1", 1,0, 0,0,0,0,  1, CA|CR|CE,       1,1, 0,0,0, 14,0));
        tbl_a.push_back(vv("t1_a2", 1,0, 0,0,0,0,  1, CA|CR,          1,2, 0,0,0, 0,0));
        tbl_a.push_back(vv("t1_f0", 0,0, 1,0,0,1,  1, CV,             0,0, 0,0,0, 0,0));
        tbl_a.push_back(vv("t1_f1", 0,0, 1,0,1,2,  1, CV|CC|CD,       0,0, 1,0,1, 0,0));
        tbl_a.push_back(vv("t1_f2", 0,0, 1,0,2,3,  1, CV|CC|CD,       0,0, 1,0,2, 0,0));
        tbl_a.push_back(vv("t1_r2", 0,0, 0,0,0,0,  1, CV|CC|CD|CE,    0,0, 1,0,3, 14,0));
        tbl_a.push_back(vv("t1_dn", 0,0, 0,0,0,0,  1, CV|CE|CX,       0,0, 0,0,0, 15,0));
        // ch1 out-of-order fill
        tbl_a.push_back(vv("t2_a0", 1,1, 0,0,0,0,  1, CA|CR|CE,       1,0, 0,0,0, 15,0));
        tbl_a.push_back(vv("t2_a1", 1,1, 0,0,0,0,  1, CA|CR|CE,       1,1, 0,0,0, 13,0));
        tbl_a.push_back(vv("t2_a2", 1,1, 0,0,0,0,  1, CA|CR,          1,2, 0,0,0, 0,0));
        tbl_a.push_back(vv("t2_a3", 1,1, 0,0,0,0,  1, CA|CR,          1,3, 0,0,0, 0,0));
        tbl_a.push_back(vv("t2_f3", 0,0, 1,1,3,13, 1, CV,             0,0, 0,0,0, 0,0));
        tbl_a.push_back(vv("t2_f1", 0,0, 1,1,1,11, 1, CV,             0,0, 0,0,0, 0,0));
        tbl_a.push_back(vv("t2_f2", 0,0, 1,1,2,12, 1, CV,             0,0, 0,0,0, 0,0));
        tbl_a.push_back(vv("t2_f0", 0,0, 1,1,0,10, 1, CV,             0,0, 0,0,0, 0,0));
        tbl_a.push_back(vv("t2_r0", 0,0, 0,0,0,0,  1, CV|CC|CD,       0,0, 1,1,10, 0,0));
        tbl_a.push_back(vv("t2_r1", 0,0, 0,0,0,0,  1, CV|CC|CD,       0,0, 1,1,11, 0,0));
        tbl_a.push_back(vv("t2_r2", 0,0, 0,0,0,0,  1, CV|CC|CD,       0,0, 1,1,12, 0,0));
        tbl_a.push_back(vv("t2_r3", 0,0, 0,0,0,0,  1, CV|CC|CD|CE,    0,0, 1,1,13, 13,0));
        tbl_a.push_back(vv("t2_dn", 0,0, 0,0,0,0,  1, CV|CE|CX,       0,0, 0,0,0, 15,0));

        // retire one ch3 entry so rr_ptr lands on 0
        tbl_b.push_back(vv("t4_p1", 1,3, 0,0,0,0,  1, CA|CR,          1,0, 0,0,0, 0,0));
        tbl_b.push_back(vv("t4_p2", 0,0, 1,3,0,20, 1, CV,             0,0, 0,0,0, 0,0));
        tbl_b.push_back(vv("t4_p3", 0,0, 0,0,0,0,  1, CV|CC|CD,       0,0, 1,3,20, 0,0));
        // ch0/ch3 heads filled, stall 3 cycles while ch1 fills
        tbl_b.push_back(vv("t4_a0", 1,0, 0,0,0,0,  1, CA|CR,          1,3, 0,0,0, 0,0));
        tbl_b.push_back(vv("t4_a3", 1,3, 0,0,0,0,  1, CA|CR,          1,1, 0,0,0, 0,0));
        tbl_b.push_back(vv("t4_a1", 1,1, 0,0,0,0,  1, CA|CR,          1,4, 0,0,0, 0,0));
        tbl_b.push_back(vv("t4_f0", 0,0, 1,0,3,21, 0, CV,             0,0, 0,0,0, 0,0));
        tbl_b.push_back(vv("t4_f3", 0,0, 1,3,1,22, 0, CV|CC|CD,       0,0, 1,0,21, 0,0));
        tbl_b.push_back(vv("t4_f1", 0,0, 1,1,4,23, 0, CV|CC|CD,       0,0, 1,0,21, 0,0));
        tbl_b.push_back(vv("t4_h0", 0,0, 0,0,0,0,  0, CV|CC|CD,       0,0, 1,0,21, 0,0));
        tbl_b.push_back(vv("t4_h1", 0,0, 0,0,0,0,  1, CV|CC|CD,       0,0, 1,0,21, 0,0));
        tbl_b.push_back(vv("t4_g1", 0,0, 0,0,0,0,  1, CV|CC|CD,       0,0, 1,1,23, 0,0));
        tbl_b.push_back(vv("t4_g3", 0,0, 0,0,0,0,  1, CV|CC|CD,       0,0, 1,3,22, 0,0));
        tbl_b.push_back(vv("t4_dn", 0,0, 0,0,0,0,  1, CV|CE,          0,0, 0,0,0, 15,0));
        // ch1 grant locked with rr_ptr=0 while ch0 becomes a candidate
        tbl_b.push_back(vv("t4_l0", 1,1, 0,0,0,0,  1, CA|CR,          1,5, 0,0,0, 0,0));
        tbl_b.push_back(vv("t4_l1", 1,0, 0,0,0,0,  1, CA|CR,          1,4, 0,0,0, 0,0));
        tbl_b.push_back(vv("t4_l2", 0,0, 1,1,5,24, 0, CV,             0,0, 0,0,0, 0,0));
        tbl_b.push_back(vv("t4_l3", 0,0, 1,0,4,25, 0, CV|CC|CD,       0,0, 1,1,24, 0,0));
        tbl_b.push_back(vv("t4_l4", 0,0, 0,0,0,0,  0, CV|CC|CD,       0,0, 1,1,24, 0,0));
        tbl_b.push_back(vv("t4_l5", 0,0, 0,0,0,0,  1, CV|CC|CD,       0,0, 1,1,24, 0,0));
        tbl_b.push_back(vv("t4_l6", 0,0, 0,0,0,0,  1, CV|CC|CD,       0,0, 1,0,25, 0,0));
        tbl_b.push_back(vv("t4_l7", 0,0, 0,0,0,0,  1, CV|CE,          0,0, 0,0,0, 15,0));
        // protocol errors: unallocated fill, then double fill
        tbl_b.push_back(vv("t5_e0", 0,0, 1,0,5,30, 1, CV|CX,          0,0, 0,0,0, 0,0));
        tbl_b.push_back(vv("t5_e1", 0,0, 0,0,0,0,  1, CV|CX,          0,0, 0,0,0, 0,1));
        tbl_b.push_back(vv("t5_e2", 1,0, 0,0,0,0,  1, CA|CR,          1,5, 0,0,0, 0,0));
        tbl_b.push_back(vv("t5_e3", 0,0, 1,0,5,31, 0, CV,             0,0, 0,0,0, 0,0));
        tbl_b.push_back(vv("t5_e4", 0,0, 1,0,5,32, 0, CV|CC|CD,       0,0, 1,0,31, 0,0));
        tbl_b.push_back(vv("t5_e5", 0,0, 0,0,0,0,  1, CV|CC|CD|CX,    0,0, 1,0,31, 0,1));
        tbl_b.push_back(vv("t5_e6", 0,0, 0,0,0,0,  1, CV|CE|CX,       0,0, 0,0,0, 15,1));

        rst_i = 1'b1;
        alloc_valid_i = 1'b1;
        alloc_channel_id_i = '0;
        sc_xbar_valid_i = 1'b0;
        sc_xbar_channel_id_i = '0;
        sc_xbar_rob_num_i = '0;
        sc_xbar_data_i = '0;
        rob_rsp_ready_i = 1'b0;
        @(negedge clk_i);
        chk("rst0.ardy", 128'(alloc_ready_o), 128'(1'b0));
        chk("rst0.sc_rdy", 128'(sc_xbar_ready_o), 128'(1'b0));

        for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i]);

        // ch2 fill to full, then wrap through 20 allocations total
        for (int k = 0; k < 8; k++)
            apply(vv("t3_alloc", 1,2, 0,0,0,0, 1, CA|CR, 1,k, 0,0,0, 0,0));
        apply(vv("t3_full", 1,2, 0,0,0,0, 1, CA|CE, 0,0, 0,0,0, 11,0));
        for (int n = 8; n < 20; n++) begin
            apply(vv("t3_head_fill", 0,0, 1,2,n%8,100+n-8, 1, CV, 0,0, 0,0,0, 0,0));
            apply(vv("t3_retire_blk", 1,2, 0,0,0,0, 1, CA|CV|CC|CD, 0,0, 1,2,100+n-8, 0,0));
            apply(vv("t3_realloc", 1,2, 0,0,0,0, 1, CA|CR|CV, 1,n%8, 0,0,0, 0,0));
        end
        for (int m = 19; m >= 12; m--)
            apply(vv("t3_rev_fill", 0,0, 1,2,m%8,100+m, 1, CV, 0,0, 0,0,0, 0,0));
        for (int m = 12; m < 20; m++)
            apply(vv("t3_drain", 0,0, 0,0,0,0, 1, CV|CC|CD, 0,0, 1,2,100+m, 0,0));
        apply(vv("t3_dn", 0,0, 0,0,0,0, 1, CV|CE, 0,0, 0,0,0, 15,0));

        for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i]);

        // reset with ch1 partially filled
        apply(vv("t6_a0", 1,1, 0,0,0,0, 0, CA|CR, 1,6, 0,0,0, 0,0));
        apply(vv("t6_a1", 1,1, 0,0,0,0, 0, CA|CR, 1,7, 0,0,0, 0,0));
        apply(vv("t6_a2", 1,1, 0,0,0,0, 0, CA|CR, 1,0, 0,0,0, 0,0));
        apply(vv("t6_a3", 1,1, 0,0,0,0, 0, CA|CR, 1,1, 0,0,0, 0,0));
        apply(vv("t6_f0", 0,0, 1,1,6,40, 0, CV, 0,0, 0,0,0, 0,0));
        apply(vv("t6_f1", 0,0, 1,1,7,41, 0, CV|CC|CD, 0,0, 1,1,40, 0,0));
        apply(vv("t6_pre", 0,0, 0,0,0,0, 0, CV|CC|CD|CE|CX, 0,0, 1,1,40, 13,1));
        @(negedge clk_i);
        rst_i = 1'b1;
        alloc_valid_i = 1'b1;
        alloc_channel_id_i = 2'd1;
        sc_xbar_valid_i = 1'b0;
        rob_rsp_ready_i = 1'b0;
        #1;
        chk("t6_rst.ardy", 128'(alloc_ready_o), 128'(1'b0));
        chk("t6_rst.sc_rdy", 128'(sc_xbar_ready_o), 128'(1'b0));
        apply(vv("t6_post", 0,0, 0,0,0,0, 0, CV|CE|CX, 0,0, 0,0,0, 15,0));
        chk("t6_post.sc_rdy", 128'(sc_xbar_ready_o), 128'(1'b1));
        apply(vv("t6_realloc", 1,1, 0,0,0,0, 0, CA|CR, 1,0, 0,0,0, 0,0));

        @(negedge clk_i);
        alloc_valid_i = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
